// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared state encoding and screen constants for the life sequencer
package life_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR      = 3'd0,
        ST_IDLE       = 3'd1,
        ST_PAINT_LOAD = 3'd2,
        ST_START      = 3'd3,
        ST_WAIT_PIX   = 3'd4,
        ST_PAINT_GEN  = 3'd5
    } life_state_e;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

endpackage

// File: rtl/life_tick_divider.sv
// rtl/life_tick_divider.sv - generation pacing counter with a single pending tick
module life_tick_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic consume,
    output logic tick_pending
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic          pending_q, pending_d;
    logic          wrap;

    always_comb begin
        wrap    = run && (count_q == CNT_LAST);
        count_d = '0;
        if (run && !wrap) begin
            count_d = count_q + CW'(1);
        end
        // A wrap landing on the consume cycle re-arms; ticks never accumulate beyond one.
        pending_d = wrap || (pending_q && !consume);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign tick_pending = pending_q;

endmodule

// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - screen clear, cell load, generation pacing and cell-to-pixel expansion
module life_sequencer
    import life_pkg::*;
#(
    parameter int GRID_W    = 4,
    parameter int GRID_H    = 4,
    parameter int CELL_SIZE = 4,
    parameter int TICK_DIV  = 50_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        step,
    input  logic        load_valid,
    input  logic [7:0]  load_x,
    input  logic [7:0]  load_y,
    output logic        load_ready,
    output logic        eng_load,
    output logic [7:0]  eng_load_x,
    output logic [7:0]  eng_load_y,
    output logic        eng_start,
    input  logic        eng_pix_valid,
    input  logic [7:0]  eng_x,
    input  logic [7:0]  eng_y,
    input  logic [2:0]  eng_colour,
    output logic        eng_pix_ready,
    input  logic        eng_done,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic [15:0] gen_count
);

    localparam int              DW       = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
    localparam logic [DW-1:0]   D_LAST   = DW'(CELL_SIZE - 1);
    localparam logic [DW-1:0]   D_SECOND = (CELL_SIZE > 1) ? DW'(1) : '0;
    localparam bit              ONE_PLOT = (CELL_SIZE == 1);
    localparam logic [7:0]      SX_LAST  = 8'(SCREEN_W - 1);
    localparam logic [6:0]      SY_LAST  = 7'(SCREEN_H - 1);

    life_state_e state_q, state_d;
    logic [7:0]  sx_q, sx_d;
    logic [6:0]  sy_q, sy_d;
    logic [DW-1:0] dx_q, dx_d, dy_q, dy_d;
    logic [7:0]  cx_q, cx_d, cy_q, cy_d;
    logic [2:0]  col_q, col_d;
    logic        done_q, done_d;
    logic        load_ready_q, load_ready_d;
    logic        eng_load_q, eng_load_d;
    logic [7:0]  eng_load_x_q, eng_load_x_d, eng_load_y_q, eng_load_y_d;
    logic        eng_start_q, eng_start_d;
    logic        pix_ready_q, pix_ready_d;
    logic [7:0]  vga_x_q, vga_x_d;
    logic [6:0]  vga_y_q, vga_y_d;
    logic [2:0]  vga_colour_q, vga_colour_d;
    logic        vga_plot_q, vga_plot_d;
    logic [15:0] gen_count_q, gen_count_d;

    logic          emit;
    logic [7:0]    em_cx, em_cy;
    logic [DW-1:0] em_dx, em_dy;
    logic [2:0]    em_col;
    logic          consume, tick_pending;

    life_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock        (clock),
        .reset_n      (reset_n),
        .run          (run),
        .consume      (consume),
        .tick_pending (tick_pending)
    );

    // Outputs are registered from the next-cycle decision, so a handshake
    // accepted at an edge shows its first plot in the very next cycle. The
    // ready flags stay low for one settling cycle after a paint finishes.
    always_comb begin
        state_d      = state_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        col_d        = col_q;
        done_d       = done_q;
        load_ready_d = 1'b0;
        eng_load_d   = 1'b0;
        eng_load_x_d = eng_load_x_q;
        eng_load_y_d = eng_load_y_q;
        eng_start_d  = 1'b0;
        pix_ready_d  = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        gen_count_d  = gen_count_q;
        consume      = 1'b0;
        emit         = 1'b0;
        em_cx        = cx_q;
        em_cy        = cy_q;
        em_dx        = dx_q;
        em_dy        = dy_q;
        em_col       = col_q;

        case (state_q)
            ST_CLEAR: begin
                vga_plot_d   = 1'b1;
                vga_x_d      = sx_q;
                vga_y_d      = sy_q;
                vga_colour_d = COLOUR_BLACK;
                if (sx_q == SX_LAST) begin
                    sx_d = '0;
                    if (sy_q == SY_LAST) begin
                        sy_d    = '0;
                        state_d = ST_IDLE;
                    end else begin
                        sy_d = sy_q + 7'd1;
                    end
                end else begin
                    sx_d = sx_q + 8'd1;
                end
            end
            ST_IDLE: begin
                if (load_valid && load_ready_q) begin
                    if (int'(load_x) < GRID_W && int'(load_y) < GRID_H) begin
                        eng_load_d   = 1'b1;
                        eng_load_x_d = load_x;
                        eng_load_y_d = load_y;
                        cx_d         = load_x;
                        cy_d         = load_y;
                        col_d        = COLOUR_WHITE;
                        emit         = 1'b1;
                        em_cx        = load_x;
                        em_cy        = load_y;
                        em_dx        = '0;
                        em_dy        = '0;
                        em_col       = COLOUR_WHITE;
                        dx_d         = D_SECOND;
                        dy_d         = '0;
                        state_d      = ONE_PLOT ? ST_IDLE : ST_PAINT_LOAD;
                    end else begin
                        // Off-grid placements are swallowed without touching the engine.
                        load_ready_d = 1'b1;
                    end
                end else if (tick_pending || step) begin
                    state_d     = ST_START;
                    eng_start_d = 1'b1;
                    consume     = 1'b1;
                end else begin
                    load_ready_d = 1'b1;
                end
            end
            ST_START: begin
                state_d     = ST_WAIT_PIX;
                pix_ready_d = 1'b1;
            end
            ST_WAIT_PIX: begin
                if (eng_pix_valid && pix_ready_q) begin
                    cx_d   = eng_x;
                    cy_d   = eng_y;
                    col_d  = eng_colour;
                    done_d = eng_done && !ONE_PLOT;
                    emit   = 1'b1;
                    em_cx  = eng_x;
                    em_cy  = eng_y;
                    em_dx  = '0;
                    em_dy  = '0;
                    em_col = eng_colour;
                    dx_d   = D_SECOND;
                    dy_d   = '0;
                    if (eng_done) begin
                        gen_count_d = gen_count_q + 16'd1;
                    end
                    if (!ONE_PLOT) begin
                        state_d = ST_PAINT_GEN;
                    end else if (eng_done) begin
                        state_d = ST_IDLE;
                    end
                end else if (eng_done) begin
                    gen_count_d = gen_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end else begin
                    pix_ready_d = 1'b1;
                end
            end
            ST_PAINT_LOAD, ST_PAINT_GEN: begin
                emit = 1'b1;
                if (dx_q == D_LAST && dy_q == D_LAST) begin
                    done_d  = 1'b0;
                    state_d = (state_q == ST_PAINT_GEN && !done_q) ? ST_WAIT_PIX : ST_IDLE;
                end else if (dx_q == D_LAST) begin
                    dx_d = '0;
                    dy_d = dy_q + DW'(1);
                end else begin
                    dx_d = dx_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // Block expander: wrap-around matches the narrow VGA coordinate ports.
        if (emit) begin
            vga_plot_d   = 1'b1;
            vga_x_d      = em_cx * 8'(CELL_SIZE) + 8'(em_dx);
            vga_y_d      = 7'(em_cy) * 7'(CELL_SIZE) + 7'(em_dy);
            vga_colour_d = em_col;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_CLEAR;
            sx_q         <= '0;
            sy_q         <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            col_q        <= '0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b0;
            eng_load_q   <= 1'b0;
            eng_load_x_q <= '0;
            eng_load_y_q <= '0;
            eng_start_q  <= 1'b0;
            pix_ready_q  <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            gen_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            col_q        <= col_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
            eng_load_q   <= eng_load_d;
            eng_load_x_q <= eng_load_x_d;
            eng_load_y_q <= eng_load_y_d;
            eng_start_q  <= eng_start_d;
            pix_ready_q  <= pix_ready_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            gen_count_q  <= gen_count_d;
        end
    end

    assign load_ready    = load_ready_q;
    assign eng_load      = eng_load_q;
    assign eng_load_x    = eng_load_x_q;
    assign eng_load_y    = eng_load_y_q;
    assign eng_start     = eng_start_q;
    assign eng_pix_ready = pix_ready_q;
    assign vga_x         = vga_x_q;
    assign vga_y         = vga_y_q;
    assign vga_colour    = vga_colour_q;
    assign vga_plot      = vga_plot_q;
    assign gen_count     = gen_count_q;

endmodule
